// File: rtl/temp_adc_sampler.sv
// temp_adc_sampler: periodic serial read of an 8-bit temperature ADC,
// saturated to 6 bits and held on temp for the over-temperature comparator.
// Optional build macro TEMP_AVG_EN: temp becomes the mean of the last four
// saturated samples instead of the latest sample.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | cs_n high, sclk low, waiting for a sample-timer tick
// START | cs_n low, one CLK_DIV setup interval before the first bit
// SHIFT | 16 sclk half-periods, one data bit taken per rising sclk
// STOP  | cs_n high, one CLK_DIV interval of deselect time
// DONE  | one cycle: temp updated, temp_valid pulsed
module temp_adc_sampler #(
  parameter int unsigned CLK_DIV       = 25,
  parameter int unsigned SAMPLE_PERIOD = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       adc_sdata,
  output logic       adc_sclk,
  output logic       adc_cs_n,
  output logic [5:0] temp,
  output logic       temp_valid,
  output logic       busy
);

  localparam int unsigned     TW       = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [TW-1:0]   TMR_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [7:0]      DIV_LOAD = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, SHIFT, STOP, DONE} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      div_q, div_d;
  logic            phase_q, phase_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [5:0]      temp_q, temp_d;
  logic            tick;
  logic            load_temp;
  logic [5:0]      sample;

  assign tick   = enable && (timer_q == TMR_LAST);
  assign sample = (shift_q > 8'd63) ? 6'd63 : shift_q[5:0];

  // Sample timer: free-runs while enabled, parked at zero otherwise.
  always_comb begin
    timer_d = timer_q;
    if (!enable || tick) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  // FSM next state; div_q is a down-counter timing each CLK_DIV interval.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    load_temp = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d   = START;
          div_d     = DIV_LOAD;
          bit_cnt_d = '0;
          phase_d   = 1'b0;
        end
      end
      START: begin
        if (div_q == 8'd0) begin
          state_d = SHIFT;
          div_d   = DIV_LOAD;
          phase_d = 1'b0;
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      SHIFT: begin
        if (div_q == 8'd0) begin
          div_d = DIV_LOAD;
          if (!phase_q) begin
            // this edge raises sclk: take the bit the ADC is presenting
            phase_d   = 1'b1;
            shift_d   = {shift_q[6:0], adc_sdata};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else begin
            phase_d = 1'b0;
            if (bit_cnt_q == 4'd8) begin
              state_d = STOP;
            end
          end
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      STOP: begin
        if (div_q == 8'd0) begin
          state_d   = DONE;
          load_temp = 1'b1;
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, timer and shift path registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      div_q     <= '0;
      phase_q   <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

`ifdef TEMP_AVG_EN
  logic [3:0][5:0] hist_q, hist_d;
  logic            primed_q, primed_d;
  logic [7:0]      sum;

  // Newest sample plus the three most recent history entries; max 4*63 fits 8 bits.
  assign sum = 8'(sample) + 8'(hist_q[0]) + 8'(hist_q[1]) + 8'(hist_q[2]);

  // History update; the first conversion after reset fills every slot.
  always_comb begin
    hist_d   = hist_q;
    primed_d = primed_q;
    temp_d   = temp_q;
    if (load_temp) begin
      if (!primed_q) begin
        hist_d   = {4{sample}};
        primed_d = 1'b1;
        temp_d   = sample;
      end else begin
        hist_d = {hist_q[2:0], sample};
        temp_d = sum[7:2];
      end
    end
  end

  // History and prime-flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q   <= '0;
      primed_q <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      primed_q <= primed_d;
    end
  end
`else
  // Output follows the latest saturated sample.
  always_comb begin
    temp_d = temp_q;
    if (load_temp) begin
      temp_d = sample;
    end
  end
`endif

  // Held temperature; only loaded on the way into DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      temp_q <= '0;
    end else begin
      temp_q <= temp_d;
    end
  end

  assign adc_cs_n   = !((state_q == START) || (state_q == SHIFT));
  assign adc_sclk   = (state_q == SHIFT) && phase_q;
  assign busy       = (state_q != IDLE);
  assign temp_valid = (state_q == DONE);
  assign temp       = temp_q;

endmodule

// File: tb/tb_temp_adc_sampler.sv
// Scoreboard bench for temp_adc_sampler: an ADC model serves codes and pushes
// the expected temperature when chip select falls; a monitor pops and compares
// on every temp_valid and checks conversion framing and period.
module tb_temp_adc_sampler;

  localparam int CD = 2;
  localparam int SP = 100;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       adc_sdata;
  logic       adc_sclk;
  logic       adc_cs_n;
  logic [5:0] temp;
  logic       temp_valid;
  logic       busy;

  temp_adc_sampler #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .adc_sdata  (adc_sdata),
    .adc_sclk   (adc_sclk),
    .adc_cs_n   (adc_cs_n),
    .temp       (temp),
    .temp_valid (temp_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: saturate, optionally average over the last four samples.
  int exp_q[$];
  int code_q[$];
`ifdef TEMP_AVG_EN
  int hist[$];
  bit primed = 1'b0;
`endif

  function automatic int ref_temp(input int code);
    int s;
    s = (code > 63) ? 63 : code;
`ifdef TEMP_AVG_EN
    if (!primed) begin
      hist = '{s, s, s, s};
      primed = 1'b1;
    end else begin
      hist.push_front(s);
      void'(hist.pop_back());
    end
    return (hist[0] + hist[1] + hist[2] + hist[3]) / 4;
`else
    return s;
`endif
  endfunction

  // ADC model: MSB presented after cs_n falls, next bit after each sclk fall.
  logic [7:0] sh = 8'h00;
  logic       m_cs_prev = 1'b1;
  logic       m_sclk_prev = 1'b0;
  always @(negedge clk) begin
    int code;
    if (!adc_cs_n && m_cs_prev) begin
      code = (code_q.size() > 0) ? code_q.pop_front() : int'($urandom_range(0, 255));
      exp_q.push_back(ref_temp(code));
      sh = 8'(code);
    end else if (!adc_cs_n && !adc_sclk && m_sclk_prev) begin
      sh = sh << 1;
    end
    adc_sdata   = sh[7];
    m_cs_prev   = adc_cs_n;
    m_sclk_prev = adc_sclk;
  end

  // Monitor: scoreboard compare on temp_valid plus framing checks.
  int   cyc = 0;
  int   vcount = 0;
  int   brise = 0;
  int   busy_len = 0;
  int   valid_len = 0;
  int   sclk_rises = 0;
  int   last_start = -1;
  logic prev_busy = 1'b0;
  logic prev_valid = 1'b0;
  logic prev_sclk = 1'b0;
  int   prev_temp = 0;
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      prev_busy  = 1'b0;
      prev_valid = 1'b0;
      prev_sclk  = 1'b0;
      busy_len   = 0;
      valid_len  = 0;
      sclk_rises = 0;
      last_start = -1;
      prev_temp  = int'(temp);
    end else begin
      if (!enable) last_start = -1;
      if (busy && !prev_busy) begin
        brise++;
        if (last_start >= 0) check("start_spacing", cyc - last_start, SP);
        last_start = cyc;
      end
      if (busy) busy_len++;
      if (adc_sclk && !prev_sclk) sclk_rises++;
      if (!busy && prev_busy) begin
        check("busy_len", busy_len, 18 * CD + 1);
        check("sclk_rises", sclk_rises, 8);
        busy_len   = 0;
        sclk_rises = 0;
      end
      if (temp_valid) begin
        valid_len++;
        if (!prev_valid) begin
          vcount++;
          check("pending_expect", exp_q.size(), 1);
          if (exp_q.size() > 0) check("temp", int'(temp), exp_q.pop_front());
        end
      end else begin
        if (prev_valid) begin
          check("valid_width", valid_len, 1);
          valid_len = 0;
        end
        if (int'(temp) != prev_temp) check("temp_hold", int'(temp), prev_temp);
      end
      prev_busy  = busy;
      prev_valid = temp_valid;
      prev_sclk  = adc_sclk;
      prev_temp  = int'(temp);
    end
  end

  task automatic wait_vcount(input int target, input int bound);
    int n = 0;
    while (vcount < target && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (vcount < target) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: got %0d valids expected %0d", vcount, target);
    end
  endtask

  task automatic wait_sclk_high(input int bound);
    int n = 0;
    while (!adc_sclk && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!adc_sclk) begin
      checks++;
      errors++;
      $display("FAIL sclk_timeout: got sclk %0d expected 1", adc_sclk);
    end
  endtask

  task automatic count_to_busy(output int n, input int bound);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!busy && n < bound);
  endtask

  initial begin
    int n;
    int v0;
    int b0;
    int viol;
    reset_n = 1'b0;
    enable  = 1'b0;
    #3;
    check("rst_cs_n", adc_cs_n, 1);
    check("rst_sclk", adc_sclk, 0);
    check("rst_temp", temp, 0);
    check("rst_valid", temp_valid, 0);
    check("rst_busy", busy, 0);

    foreach (code_q[i]) ; // queue starts empty
    code_q = '{20, 24, 28, 32, 8'h19, 8'hC8, 8'h3F, 8'h1C};
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    enable  = 1'b1;
    count_to_busy(n, 3 * SP);
    check("first_start", n, SP);
    // 8 directed codes then 6 random ones from the ADC model
    wait_vcount(14, 15 * SP);

    // enable low from idle: no activity at all
    enable = 1'b0;
    v0 = vcount;
    viol = 0;
    repeat (1000) begin
      @(negedge clk);
      if (!adc_cs_n || adc_sclk) viol++;
    end
    check("gated_idle", viol, 0);
    check("gated_no_valid", vcount, v0);

    // drop enable mid-shift: conversion completes, no new start
    @(negedge clk);
    enable = 1'b1;
    count_to_busy(n, 3 * SP);
    check("enable_to_start", n, SP);
    wait_sclk_high(4 * CD + 4);
    enable = 1'b0;
    wait_vcount(v0 + 1, 40 * CD);
    b0 = brise;
    repeat (3 * SP) @(negedge clk);
    check("no_restart", brise, b0);

    // async reset mid-shift
    code_q.push_back(8'h19);
    enable = 1'b1;
    wait_vcount(v0 + 2, 3 * SP);
    code_q.push_back(8'h30);
    wait_sclk_high(3 * SP);
    #1 reset_n = 1'b0;
    #1;
    check("arst_cs_n", adc_cs_n, 1);
    check("arst_sclk", adc_sclk, 0);
    check("arst_temp", temp, 0);
    check("arst_busy", busy, 0);
    check("arst_valid", temp_valid, 0);
    exp_q.delete();
`ifdef TEMP_AVG_EN
    primed = 1'b0;
`endif
    code_q.push_back(42);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    count_to_busy(n, 3 * SP);
    check("reset_to_start", n, SP);
    wait_vcount(v0 + 3, 3 * SP);
    check("post_reset_temp", temp, 42);
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
